// File: rtl/bicycle_mode_ctrl.sv
// Rear-light mode sequencer and per-blinker rate controller.
// Optional idle auto-off timer compiled in with `define AUTO_OFF_EN.
module bicycle_mode_ctrl #(
  parameter int RATE_W     = 3,
  parameter int FAST_INIT  = 2,
  parameter int SLOW_INIT  = 5,
  parameter int RATE_MIN   = 0,
  parameter int RATE_MAX   = 7,
  parameter int IDLE_BEATS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  input  logic              next,
  input  logic              faster,
  input  logic              slower,
  output logic [1:0]        mode,
  output logic [RATE_W-1:0] rate,
  output logic              fast_shl,
  output logic              fast_shr,
  output logic              slow_shl,
  output logic              slow_shr
);

  typedef enum logic [1:0] {
    M_OFF  = 2'b00,
    M_ON   = 2'b01,
    M_FAST = 2'b10,
    M_SLOW = 2'b11
  } mode_t;

  localparam logic [RATE_W-1:0] R_MIN = RATE_W'(RATE_MIN);
  localparam logic [RATE_W-1:0] R_MAX = RATE_W'(RATE_MAX);

  mode_t             st;
  logic [RATE_W-1:0] fast_rate;
  logic [RATE_W-1:0] slow_rate;
  logic              next_q;
  logic              faster_q;
  logic              slower_q;
  logic              armed;
  logic              next_e;
  logic              faster_e;
  logic              slower_e;
  logic              any_e;
  logic              go_up;
  logic              go_dn;
  logic              timeout;

  // armed masks the first cycle so a button held through reset is not an edge
  assign next_e   = armed & next & ~next_q;
  assign faster_e = armed & faster & ~faster_q;
  assign slower_e = armed & slower & ~slower_q;
  assign any_e    = next_e | faster_e | slower_e;
  assign go_dn    = faster_e & ~slower_e;
  assign go_up    = slower_e & ~faster_e;

`ifdef AUTO_OFF_EN
  localparam int CNT_W = $clog2(IDLE_BEATS + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(IDLE_BEATS);

  logic [CNT_W-1:0] idle_cnt;

  assign timeout = (idle_cnt == C_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (any_e || timeout || st == M_OFF) begin
      idle_cnt <= '0;
    end else if (beat && idle_cnt != C_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic unused_ok;

  assign timeout   = 1'b0;
  assign unused_ok = beat ^ (IDLE_BEATS == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= M_OFF;
      fast_rate <= RATE_W'(FAST_INIT);
      slow_rate <= RATE_W'(SLOW_INIT);
      next_q    <= 1'b0;
      faster_q  <= 1'b0;
      slower_q  <= 1'b0;
      armed     <= 1'b0;
      fast_shl  <= 1'b0;
      fast_shr  <= 1'b0;
      slow_shl  <= 1'b0;
      slow_shr  <= 1'b0;
    end else begin
      armed    <= 1'b1;
      next_q   <= next;
      faster_q <= faster;
      slower_q <= slower;
      fast_shl <= 1'b0;
      fast_shr <= 1'b0;
      slow_shl <= 1'b0;
      slow_shr <= 1'b0;
      if (next_e) begin
        unique case (st)
          M_OFF:   st <= M_ON;
          M_ON:    st <= M_FAST;
          M_FAST:  st <= M_SLOW;
          default: st <= M_OFF;
        endcase
      end else if (timeout && !any_e) begin
        st <= M_OFF;
      end else if (st == M_FAST) begin
        if (go_dn && fast_rate != R_MIN) begin
          fast_rate <= fast_rate - 1'b1;
          fast_shr  <= 1'b1;
        end else if (go_up && fast_rate != R_MAX) begin
          fast_rate <= fast_rate + 1'b1;
          fast_shl  <= 1'b1;
        end
      end else if (st == M_SLOW) begin
        if (go_dn && slow_rate != R_MIN) begin
          slow_rate <= slow_rate - 1'b1;
          slow_shr  <= 1'b1;
        end else if (go_up && slow_rate != R_MAX) begin
          slow_rate <= slow_rate + 1'b1;
          slow_shl  <= 1'b1;
        end
      end
    end
  end

  assign mode = st;

  always_comb begin
    rate = '0;
    unique case (st)
      M_FAST:  rate = fast_rate;
      M_SLOW:  rate = slow_rate;
      default: rate = '0;
    endcase
  end

endmodule

// File: tb/tb_bicycle_mode_ctrl.sv
// Directed self-checking bench for bicycle_mode_ctrl.
// Auto-off scenario runs only when AUTO_OFF_EN is defined.
module tb_bicycle_mode_ctrl;

  logic       clk;
  logic       reset;
  logic       beat;
  logic       next;
  logic       faster;
  logic       slower;
  logic [1:0] mode;
  logic [2:0] rate;
  logic       fast_shl;
  logic       fast_shr;
  logic       slow_shl;
  logic       slow_shr;

  int total;
  int bad;

  bicycle_mode_ctrl #(
    .RATE_W    (3),
    .FAST_INIT (2),
    .SLOW_INIT (5),
    .RATE_MIN  (0),
    .RATE_MAX  (7),
    .IDLE_BEATS(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .beat    (beat),
    .next    (next),
    .faster  (faster),
    .slower  (slower),
    .mode    (mode),
    .rate    (rate),
    .fast_shl(fast_shl),
    .fast_shr(fast_shr),
    .slow_shl(slow_shl),
    .slow_shr(slow_shr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pulses();
    return {fast_shl, fast_shr, slow_shl, slow_shr};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // One press: rise, check the registered result, then release.
  task automatic press(input int b, input logic [1:0] m_exp,
                       input logic [2:0] r_exp, input logic [3:0] p_exp,
                       input string tag);
    if (b == 0) next = 1'b1;
    if (b == 1) faster = 1'b1;
    if (b == 2) slower = 1'b1;
    tick();
    total++;
    if (mode !== m_exp || rate !== r_exp || pulses() !== p_exp) begin
      bad++;
      $display("FAIL %s: mode=%b rate=%0d pulses=%b want mode=%b rate=%0d pulses=%b",
               tag, mode, rate, pulses(), m_exp, r_exp, p_exp);
    end
    next = 1'b0;
    faster = 1'b0;
    slower = 1'b0;
    tick();
    total++;
    if (mode !== m_exp || pulses() !== 4'b0000) begin
      bad++;
      $display("FAIL %s_release: mode=%b pulses=%b want mode=%b pulses=0000",
               tag, mode, pulses(), m_exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if (mode !== 2'b00 || rate !== 3'd0 || pulses() !== 4'b0000) begin
      bad++;
      $display("FAIL reset: mode=%b rate=%0d pulses=%b want 00/0/0000",
               mode, rate, pulses());
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mode_cycle();
    press(0, 2'b01, 3'd0, 4'b0000, "cyc_on");
    press(0, 2'b10, 3'd2, 4'b0000, "cyc_fast");
    press(0, 2'b11, 3'd5, 4'b0000, "cyc_slow");
    press(0, 2'b00, 3'd0, 4'b0000, "cyc_off");
    // holding next must advance only once
    next = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (mode !== 2'b01) begin
      bad++;
      $display("FAIL hold_next: mode=%b want 01", mode);
    end
    next = 1'b0;
    tick();
  endtask

  task automatic test_ignored();
    // currently ON: rate buttons do nothing
    press(1, 2'b01, 3'd0, 4'b0000, "on_faster");
    press(2, 2'b01, 3'd0, 4'b0000, "on_slower");
  endtask

  task automatic test_fast_rate();
    do_reset();
    press(0, 2'b01, 3'd0, 4'b0000, "f_on");
    press(0, 2'b10, 3'd2, 4'b0000, "f_fast");
    press(1, 2'b10, 3'd1, 4'b0100, "f_dn1");
    press(1, 2'b10, 3'd0, 4'b0100, "f_dn0");
    press(1, 2'b10, 3'd0, 4'b0000, "f_sat_min");
    press(2, 2'b10, 3'd1, 4'b1000, "f_up1");
  endtask

  task automatic test_slow_rate();
    do_reset();
    press(0, 2'b01, 3'd0, 4'b0000, "s_on");
    press(0, 2'b10, 3'd2, 4'b0000, "s_fast");
    press(0, 2'b11, 3'd5, 4'b0000, "s_slow");
    press(2, 2'b11, 3'd6, 4'b0010, "s_up6");
    press(2, 2'b11, 3'd7, 4'b0010, "s_up7");
    press(2, 2'b11, 3'd7, 4'b0000, "s_sat_max");
    press(0, 2'b00, 3'd0, 4'b0000, "s_off");
    press(0, 2'b01, 3'd0, 4'b0000, "s_on2");
    press(0, 2'b10, 3'd2, 4'b0000, "s_fast_kept");
    press(0, 2'b11, 3'd7, 4'b0000, "s_slow_kept");
    press(1, 2'b11, 3'd6, 4'b0001, "s_dn6");
  endtask

  task automatic test_priority();
    do_reset();
    press(0, 2'b01, 3'd0, 4'b0000, "p_on");
    press(0, 2'b10, 3'd2, 4'b0000, "p_fast");
    next = 1'b1;
    press(1, 2'b11, 3'd5, 4'b0000, "p_next_wins");
    press(0, 2'b00, 3'd0, 4'b0000, "p_off");
    press(0, 2'b01, 3'd0, 4'b0000, "p_on2");
    press(0, 2'b10, 3'd2, 4'b0000, "p_fast_unch");
    slower = 1'b1;
    press(1, 2'b10, 3'd2, 4'b0000, "p_both");
  endtask

  task automatic test_back_to_back();
    // faster then slower in consecutive cycles in FAST: 2->1->2
    faster = 1'b1;
    tick();
    total++;
    if (rate !== 3'd1 || pulses() !== 4'b0100) begin
      bad++;
      $display("FAIL b2b_1: rate=%0d pulses=%b want 1/0100", rate, pulses());
    end
    faster = 1'b0;
    slower = 1'b1;
    tick();
    total++;
    if (rate !== 3'd2 || pulses() !== 4'b1000) begin
      bad++;
      $display("FAIL b2b_2: rate=%0d pulses=%b want 2/1000", rate, pulses());
    end
    slower = 1'b0;
    tick();
  endtask

  task automatic test_reset_hold();
    reset = 1'b0;
    next = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (mode !== 2'b00) begin
      bad++;
      $display("FAIL hold_through_reset: mode=%b want 00", mode);
    end
    next = 1'b0;
    tick();
    press(0, 2'b01, 3'd0, 4'b0000, "r_on");
    press(0, 2'b10, 3'd2, 4'b0000, "r_fast");
    faster = 1'b1;
    tick();
    // assert reset while fast_shr is high, between clock edges
    reset = 1'b0;
    #1;
    total++;
    if (mode !== 2'b00 || rate !== 3'd0 || pulses() !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: mode=%b rate=%0d pulses=%b want 00/0/0000",
               mode, rate, pulses());
    end
    faster = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    press(0, 2'b01, 3'd0, 4'b0000, "r_on2");
    press(0, 2'b10, 3'd2, 4'b0000, "r_fast_init");
  endtask

`ifdef AUTO_OFF_EN
  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      tick();
    end
  endtask

  task automatic test_auto_off();
    do_reset();
    press(0, 2'b01, 3'd0, 4'b0000, "a_on");
    beats(3);
    total++;
    if (mode !== 2'b01) begin
      bad++;
      $display("FAIL auto_3beats: mode=%b want 01", mode);
    end
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
    total++;
    if (mode !== 2'b00 || pulses() !== 4'b0000) begin
      bad++;
      $display("FAIL auto_off: mode=%b pulses=%b want 00/0000", mode, pulses());
    end
    press(0, 2'b01, 3'd0, 4'b0000, "a_on2");
    beats(3);
    press(1, 2'b01, 3'd0, 4'b0000, "a_restart");
    beats(3);
    total++;
    if (mode !== 2'b01) begin
      bad++;
      $display("FAIL auto_restart: mode=%b want 01", mode);
    end
    beats(1);
    total++;
    if (mode !== 2'b00) begin
      bad++;
      $display("FAIL auto_off2: mode=%b want 00", mode);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    beat = 1'b0;
    next = 1'b0;
    faster = 1'b0;
    slower = 1'b0;
    test_reset();
    test_mode_cycle();
    test_ignored();
    test_fast_rate();
    test_slow_rate();
    test_priority();
    test_back_to_back();
    test_reset_hold();
`ifdef AUTO_OFF_EN
    test_auto_off();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
